// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg
// Shared definitions for the instruction-memory program loader:
//   - loader FSM state encoding
//   - default inter-byte timeout
//   - helper that tells whether a state accepts stream bytes
package prog_loader_pkg;

  // Default maximum number of cycles allowed between accepted bytes while a
  // frame is open.
  localparam int TIMEOUT_DEFAULT = 1000;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LEN  = 3'd1;
  localparam logic [2:0] ST_HI   = 3'd2;
  localparam logic [2:0] ST_LO   = 3'd3;
  localparam logic [2:0] ST_CHK  = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;
  localparam logic [2:0] ST_ERR  = 3'd6;

  // States in which a frame is open: the loader takes bytes and the idle-cycle
  // timeout is running.
  function automatic logic is_accepting(input state_t s);
    return (s == ST_LEN) || (s == ST_HI) || (s == ST_LO) || (s == ST_CHK);
  endfunction

endpackage

// File: rtl/prog_loader_timeout.sv
// loader_timeout
// Idle-cycle counter used while a frame is open. Counts cycles since the last
// clear and flags expiry when TIMEOUT-1 cycles have gone by without one.
// Ports:
//   clk     in   system clock
//   rst     in   synchronous active-high reset
//   run     in   counting enabled (frame open); counter is held at 0 otherwise
//   clear   in   restart the count (byte accepted or state entered)
//   expire  out  count has reached TIMEOUT-1 while running
module loader_timeout
  import prog_loader_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // The count saturates at LAST; the FSM leaves the open-frame states as soon
  // as expire is seen, which stops and clears the counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear || !run) begin
      count <= '0;
    end else if (count != LAST) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expire = run && (count == LAST);

endmodule

// File: rtl/prog_loader.sv
// prog_loader
// Writer side of the instruction memory. Receives a framed byte stream
//   LEN, {HI, LO} x LEN, CHK
// over a valid/ready handshake, assembles big-endian 16-bit words, writes them
// to consecutive instruction addresses starting at BASE_ADDR and keeps the CPU
// held until the whole frame has arrived with a matching XOR checksum.
// Ports:
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   start       in   one-cycle pulse opening a frame (IDLE, DONE or ERR only)
//   byte_valid  in   source presents a byte
//   byte_data   in   stream byte
//   byte_ready  out  loader accepts a byte this cycle
//   imem_we     out  instruction-memory write strobe, one cycle per word
//   imem_addr   out  instruction-memory write address
//   imem_wdata  out  instruction-memory write data
//   cpu_hold    out  keeps the CPU stopped; low only once a frame verified
//   done        out  frame loaded and verified
//   error       out  checksum mismatch or inter-byte timeout
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                TIMEOUT   = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  state_t     state;
  state_t     next_state;
  logic [7:0] chk;
  logic [7:0] hi_byte;
  logic [7:0] remaining;
  logic       xfer;
  logic       frame_open;
  logic       expire;
  logic       tmo_clear;

  assign xfer       = byte_valid && byte_ready;
  assign frame_open = is_accepting(state);
  // Restart the idle count on every accepted byte and on every state change.
  assign tmo_clear  = xfer || (next_state != state);

  loader_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .run    (frame_open),
    .clear  (tmo_clear),
    .expire (expire)
  );

  // Next-state logic. In every open-frame state an accepted byte takes
  // priority over a timeout expiring in the same cycle.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) next_state = ST_LEN;
      end
      ST_LEN: begin
        if (xfer)        next_state = (byte_data == 8'd0) ? ST_CHK : ST_HI;
        else if (expire) next_state = ST_ERR;
      end
      ST_HI: begin
        if (xfer)        next_state = ST_LO;
        else if (expire) next_state = ST_ERR;
      end
      ST_LO: begin
        if (xfer)        next_state = (remaining > 8'd1) ? ST_HI : ST_CHK;
        else if (expire) next_state = ST_ERR;
      end
      ST_CHK: begin
        if (xfer)        next_state = (byte_data == chk) ? ST_DONE : ST_ERR;
        else if (expire) next_state = ST_ERR;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // State, registered status outputs and datapath. The status outputs are
  // registered from next_state so they always describe the current state
  // without a combinational path from the inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      byte_ready <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= '0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      chk        <= '0;
      hi_byte    <= '0;
      remaining  <= '0;
    end else begin
      state      <= next_state;
      byte_ready <= is_accepting(next_state);
      cpu_hold   <= (next_state != ST_DONE);
      done       <= (next_state == ST_DONE);
      error      <= (next_state == ST_ERR);
      imem_we    <= 1'b0;

      // The address presented with a write strobe is the one written; advance
      // afterwards, wrapping naturally at 2^ADDR_W.
      if (imem_we) imem_addr <= imem_addr + ADDR_W'(1);

      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            chk       <= '0;
            imem_addr <= BASE_ADDR;
          end
        end
        ST_LEN: begin
          if (xfer) begin
            remaining <= byte_data;
            chk       <= byte_data;
          end
        end
        ST_HI: begin
          if (xfer) begin
            hi_byte <= byte_data;
            chk     <= chk ^ byte_data;
          end
        end
        ST_LO: begin
          if (xfer) begin
            chk        <= chk ^ byte_data;
            imem_we    <= 1'b1;
            imem_wdata <= {hi_byte, byte_data};
            remaining  <= remaining - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
